// File: rtl/boot_mode_pkg.sv
// Shared types and constants for the boot-mode controller: FSM state encoding,
// loader word-access constants and the saturating write-counter helper.
package boot_mode_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } boot_state_t;

  localparam logic [2:0]  LOAD_TYPE_WORD   = 3'b111;
  localparam int          UPG_DMEM_SEL_BIT = 14;
  localparam int          WORD_COUNT_W     = 15;
  localparam logic [14:0] WORD_COUNT_MAX   = 15'h7FFF;

  // Counts every loader write but never wraps, so a runaway loader stays visible.
  function automatic logic [14:0] sat_inc_count(input logic [14:0] value);
    return (value == WORD_COUNT_MAX) ? value : value + 15'd1;
  endfunction

endpackage

// File: rtl/boot_mode_ctrl_if.sv
// Bundle of loader, CPU and memory-port signals around the boot-mode controller.
// The controller takes the slave view; the surrounding SoC or bench takes master.
interface boot_mode_ctrl_if;
  import boot_mode_pkg::*;

  logic        start_uart;

  logic        upg_wen;
  logic [14:0] upg_addr;
  logic [31:0] upg_data;
  logic        upg_done;

  logic [15:0] cpu_pc;
  logic        cpu_mem_write;
  logic [31:0] cpu_daddr;
  logic [2:0]  cpu_load_type;
  logic [31:0] cpu_wdata;

  logic        upg_rst;
  logic        cpu_hold;

  logic        imem_wea;
  logic [13:0] imem_addr;
  logic [31:0] imem_din;

  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [2:0]  dmem_load_type;
  logic [31:0] dmem_din;

  logic [1:0]  mode;
  logic [14:0] word_count;
  logic        load_err;
  logic        load_abort;

  modport slave (
    input  start_uart,
    input  upg_wen, upg_addr, upg_data, upg_done,
    input  cpu_pc, cpu_mem_write, cpu_daddr, cpu_load_type, cpu_wdata,
    output upg_rst, cpu_hold,
    output imem_wea, imem_addr, imem_din,
    output dmem_we, dmem_addr, dmem_load_type, dmem_din,
    output mode, word_count, load_err, load_abort
  );

  modport master (
    output start_uart,
    output upg_wen, upg_addr, upg_data, upg_done,
    output cpu_pc, cpu_mem_write, cpu_daddr, cpu_load_type, cpu_wdata,
    input  upg_rst, cpu_hold,
    input  imem_wea, imem_addr, imem_din,
    input  dmem_we, dmem_addr, dmem_load_type, dmem_din,
    input  mode, word_count, load_err, load_abort
  );

endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for the
// start_uart switch; the output level only moves after a stable run of samples.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous, sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      // r_cnt holds how many differing samples have been seen back to back.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/boot_mode_ctrl.sv
// Boot-mode controller: freezes the CPU while a UART loader writes IMEM/DMEM,
// then releases it from PC 0 once the start switch is dropped.
module boot_mode_ctrl
  import boot_mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DMEM_WORDS      = 16384
) (
  input  logic             clk,
  input  logic             reset,
  boot_mode_ctrl_if.slave  bus
);

  localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_WORDS);

  boot_state_t       r_state;
  boot_state_t       w_next_state;
  logic [14:0]       r_word_count;
  logic              r_load_err;
  logic              r_load_abort;

  logic              w_start_db;
  logic [13:0]       w_upg_idx;
  logic              w_upg_is_dmem;
  logic              w_dmem_in_range;
  logic              w_load_wen;
  logic              w_out_of_range;
  logic              w_enter_hold;
  logic              w_abort;
  logic              w_unused_pc_lsbs;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.start_uart),
    .o_level (w_start_db)
  );

  assign w_upg_idx        = bus.upg_addr[13:0];
  assign w_upg_is_dmem    = bus.upg_addr[UPG_DMEM_SEL_BIT];
  assign w_dmem_in_range  = ({18'd0, w_upg_idx} < DMEM_LIMIT);
  assign w_load_wen       = (r_state == ST_LOAD) && bus.upg_wen;
  assign w_out_of_range   = w_load_wen && w_upg_is_dmem && !w_dmem_in_range;
  assign w_enter_hold     = (r_state == ST_RUN) && w_start_db;
  assign w_abort          = (r_state == ST_LOAD) && !w_start_db && !bus.upg_done;
  assign w_unused_pc_lsbs = ^bus.cpu_pc[1:0];

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_RUN:  if (w_start_db) w_next_state = ST_HOLD;
      ST_HOLD: w_next_state = ST_LOAD;
      // A finished load takes priority over a simultaneous switch release.
      ST_LOAD: begin
        if (bus.upg_done)     w_next_state = ST_DONE;
        else if (!w_start_db) w_next_state = ST_RUN;
      end
      ST_DONE: if (!w_start_db) w_next_state = ST_RUN;
      default: w_next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_word_count <= '0;
      r_load_err   <= 1'b0;
      r_load_abort <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_enter_hold) begin
        r_word_count <= '0;
        r_load_err   <= 1'b0;
        r_load_abort <= 1'b0;
      end else begin
        if (w_load_wen)     r_word_count <= sat_inc_count(r_word_count);
        if (w_out_of_range) r_load_err   <= 1'b1;
        if (w_abort)        r_load_abort <= 1'b1;
      end
    end
  end

  // Memory-port muxes depend only on the registered state, so a mode change
  // takes effect on the same edge the state register updates.
  always_comb begin
    bus.upg_rst        = 1'b1;
    bus.cpu_hold       = 1'b1;
    bus.imem_wea       = 1'b0;
    bus.imem_addr      = bus.cpu_pc[15:2];
    bus.imem_din       = 32'd0;
    bus.dmem_we        = 1'b0;
    bus.dmem_addr      = bus.cpu_daddr;
    bus.dmem_load_type = bus.cpu_load_type;
    bus.dmem_din       = bus.cpu_wdata;
    unique case (r_state)
      ST_RUN: begin
        bus.cpu_hold = 1'b0;
        bus.dmem_we  = bus.cpu_mem_write;
      end
      ST_LOAD: begin
        bus.upg_rst        = 1'b0;
        bus.imem_wea       = bus.upg_wen && !w_upg_is_dmem;
        bus.imem_addr      = w_upg_idx;
        bus.imem_din       = bus.upg_data;
        bus.dmem_we        = bus.upg_wen && w_upg_is_dmem && w_dmem_in_range;
        bus.dmem_addr      = {16'd0, w_upg_idx, 2'b00};
        bus.dmem_load_type = LOAD_TYPE_WORD;
        bus.dmem_din       = bus.upg_data;
      end
      default: ;
    endcase
  end

  assign bus.mode       = r_state;
  assign bus.word_count = r_word_count;
  assign bus.load_err   = r_load_err;
  assign bus.load_abort = r_load_abort;

endmodule

// File: tb/tb_boot_mode_ctrl.sv
// Directed bench for boot_mode_ctrl: table-driven port-mux vectors in RUN and
// LOAD plus hand-written sequences for debounce timing, abort, DONE and reset.
module tb_boot_mode_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  boot_mode_ctrl_if bus ();

  boot_mode_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .DMEM_WORDS      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] pc;
    logic        mw;
    logic [31:0] daddr;
    logic [2:0]  lt;
    logic [31:0] wdata;
    logic [13:0] exp_iaddr;
  } run_vec_t;

  typedef struct {
    logic        wen;
    logic [14:0] addr;
    logic [31:0] data;
    logic        exp_iwea;
    logic [13:0] exp_iaddr;
    logic        exp_dwe;
    logic [31:0] exp_daddr;
    logic [14:0] exp_wc;
    logic        exp_err;
  } load_vec_t;

  run_vec_t  rv [3];
  load_vec_t lv [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rv[0] = '{16'h1234, 1'b1, 32'h1000_0040, 3'b010, 32'h55AA_55AA, 14'h048D};
    rv[1] = '{16'hFFFF, 1'b0, 32'hFFFF_FFFC, 3'b000, 32'h0000_0000, 14'h3FFF};
    rv[2] = '{16'h0000, 1'b1, 32'h0000_0004, 3'b101, 32'h0F0F_0F0F, 14'h0000};

    lv[0] = '{1'b1, 15'h0003, 32'hDEAD_BEEF, 1'b1, 14'h0003, 1'b0, 32'h0000_000C, 15'd1, 1'b0};
    lv[1] = '{1'b1, 15'h4005, 32'h1234_5678, 1'b0, 14'h0005, 1'b1, 32'h0000_0014, 15'd2, 1'b0};
    lv[2] = '{1'b0, 15'h0007, 32'hA5A5_A5A5, 1'b0, 14'h0007, 1'b0, 32'h0000_001C, 15'd2, 1'b0};
    lv[3] = '{1'b1, 15'h4007, 32'h0BAD_F00D, 1'b0, 14'h0007, 1'b1, 32'h0000_001C, 15'd3, 1'b0};
    lv[4] = '{1'b1, 15'h4008, 32'hCAFE_F00D, 1'b0, 14'h0008, 1'b0, 32'h0000_0020, 15'd4, 1'b1};
    lv[5] = '{1'b1, 15'h7FFF, 32'h1111_2222, 1'b0, 14'h3FFF, 1'b0, 32'h0000_FFFC, 15'd5, 1'b1};
    lv[6] = '{1'b1, 15'h0001, 32'h3333_4444, 1'b1, 14'h0001, 1'b0, 32'h0000_0004, 15'd6, 1'b1};

    reset             = 1'b1;
    bus.start_uart    = 1'b0;
    bus.upg_wen       = 1'b0;
    bus.upg_addr      = '0;
    bus.upg_data      = '0;
    bus.upg_done      = 1'b0;
    bus.cpu_pc        = '0;
    bus.cpu_mem_write = 1'b0;
    bus.cpu_daddr     = '0;
    bus.cpu_load_type = '0;
    bus.cpu_wdata     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bus.cpu_mem_write = 1'b1;
    @(negedge clk);
    check("rst_mode",       32'(bus.mode), 32'd0);
    check("rst_upg_rst",    32'(bus.upg_rst), 32'd1);
    check("rst_cpu_hold",   32'(bus.cpu_hold), 32'd0);
    check("rst_imem_wea",   32'(bus.imem_wea), 32'd0);
    check("rst_dmem_we",    32'(bus.dmem_we), 32'd1);
    check("rst_word_count", 32'(bus.word_count), 32'd0);
    check("rst_load_err",   32'(bus.load_err), 32'd0);
    check("rst_load_abort", 32'(bus.load_abort), 32'd0);

    // RUN pass-through, with a stray loader write that must be ignored
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.cpu_pc        = rv[i].pc;
      bus.cpu_mem_write = rv[i].mw;
      bus.cpu_daddr     = rv[i].daddr;
      bus.cpu_load_type = rv[i].lt;
      bus.cpu_wdata     = rv[i].wdata;
      bus.upg_wen       = 1'b1;
      bus.upg_addr      = 15'h0003;
      bus.upg_data      = 32'hFFFF_FFFF;
      @(negedge clk);
      check("run_imem_addr",  32'(bus.imem_addr), 32'(rv[i].exp_iaddr));
      check("run_imem_wea",   32'(bus.imem_wea), 32'd0);
      check("run_imem_din",   bus.imem_din, 32'd0);
      check("run_dmem_we",    32'(bus.dmem_we), 32'(rv[i].mw));
      check("run_dmem_addr",  bus.dmem_addr, rv[i].daddr);
      check("run_dmem_lt",    32'(bus.dmem_load_type), 32'(rv[i].lt));
      check("run_dmem_din",   bus.dmem_din, rv[i].wdata);
    end
    @(posedge clk);
    #1;
    check("run_wen_ignored_count", 32'(bus.word_count), 32'd0);
    bus.upg_wen       = 1'b0;
    bus.cpu_mem_write = 1'b1;

    // Two-cycle glitch on start_uart must not leave RUN
    bus.start_uart = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 bus.start_uart = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      check("glitch_mode", 32'(bus.mode), 32'd0);
    end

    // Clean rise: HOLD after 2+4 edges, LOAD one edge later
    @(posedge clk);
    #1 bus.start_uart = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rise_mode", 32'(bus.mode), (k < 6) ? 32'd0 : ((k == 6) ? 32'd1 : 32'd2));
      if (k == 6) begin
        check("hold_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("hold_upg_rst",  32'(bus.upg_rst), 32'd1);
        check("hold_dmem_we",  32'(bus.dmem_we), 32'd0);
      end
      if (k == 7) check("load_upg_rst", 32'(bus.upg_rst), 32'd0);
    end

    // Loader writes in LOAD
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      bus.upg_wen  = lv[i].wen;
      bus.upg_addr = lv[i].addr;
      bus.upg_data = lv[i].data;
      @(negedge clk);
      check("load_imem_wea",  32'(bus.imem_wea), 32'(lv[i].exp_iwea));
      check("load_imem_addr", 32'(bus.imem_addr), 32'(lv[i].exp_iaddr));
      check("load_imem_din",  bus.imem_din, lv[i].data);
      check("load_dmem_we",   32'(bus.dmem_we), 32'(lv[i].exp_dwe));
      check("load_dmem_addr", bus.dmem_addr, lv[i].exp_daddr);
      check("load_dmem_lt",   32'(bus.dmem_load_type), 32'h7);
      check("load_dmem_din",  bus.dmem_din, lv[i].data);
      @(posedge clk);
      #1;
      check("load_word_count", 32'(bus.word_count), 32'(lv[i].exp_wc));
      check("load_err",        32'(bus.load_err), 32'(lv[i].exp_err));
    end
    bus.upg_wen = 1'b0;

    // upg_done coincides with start_db falling: DONE wins, no abort
    bus.start_uart = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("fall_mode", 32'(bus.mode), 32'd2);
    end
    @(posedge clk);
    #1 bus.upg_done = 1'b1;
    @(negedge clk);
    check("fall_pre_done_mode", 32'(bus.mode), 32'd2);
    @(posedge clk);
    #1;
    bus.upg_done = 1'b0;
    bus.upg_wen  = 1'b1;
    bus.upg_addr = 15'h0002;
    bus.cpu_pc   = 16'h0040;
    @(negedge clk);
    check("done_mode",       32'(bus.mode), 32'd3);
    check("done_load_abort", 32'(bus.load_abort), 32'd0);
    check("done_cpu_hold",   32'(bus.cpu_hold), 32'd1);
    check("done_upg_rst",    32'(bus.upg_rst), 32'd1);
    check("done_imem_wea",   32'(bus.imem_wea), 32'd0);
    check("done_dmem_we",    32'(bus.dmem_we), 32'd0);
    check("done_imem_addr",  32'(bus.imem_addr), 32'h10);
    @(posedge clk);
    #1;
    bus.upg_wen = 1'b0;
    check("ret_mode",       32'(bus.mode), 32'd0);
    check("ret_cpu_hold",   32'(bus.cpu_hold), 32'd0);
    check("ret_dmem_we",    32'(bus.dmem_we), 32'd1);
    check("ret_word_count", 32'(bus.word_count), 32'd6);
    check("ret_load_err",   32'(bus.load_err), 32'd1);

    // New load clears the flags; then dropping the switch aborts it
    bus.start_uart = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("reload_mode", 32'(bus.mode), (k < 6) ? 32'd0 : ((k == 6) ? 32'd1 : 32'd2));
      if (k == 6) begin
        check("reload_word_count", 32'(bus.word_count), 32'd0);
        check("reload_load_err",   32'(bus.load_err), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    bus.upg_wen  = 1'b1;
    bus.upg_addr = 15'h4001;
    @(posedge clk);
    #1;
    bus.upg_wen = 1'b0;
    check("abort_pre_count", 32'(bus.word_count), 32'd1);
    bus.start_uart = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_mode", 32'(bus.mode), (k < 6) ? 32'd2 : 32'd0);
    end
    check("abort_flag",     32'(bus.load_abort), 32'd1);
    check("abort_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    check("abort_count",    32'(bus.word_count), 32'd1);

    // Reset in the middle of a load
    @(posedge clk);
    #1 bus.start_uart = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rl_mode",       32'(bus.mode), 32'd2);
    check("rl_load_abort", 32'(bus.load_abort), 32'd0);
    bus.cpu_mem_write = 1'b0;
    bus.upg_wen       = 1'b1;
    bus.upg_addr      = 15'h0004;
    @(posedge clk);
    #1;
    check("rl_count", 32'(bus.word_count), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rl_rst_mode",     32'(bus.mode), 32'd0);
    check("rl_rst_imem_wea", 32'(bus.imem_wea), 32'd0);
    check("rl_rst_dmem_we",  32'(bus.dmem_we), 32'd0);
    check("rl_rst_count",    32'(bus.word_count), 32'd0);
    check("rl_rst_upg_rst",  32'(bus.upg_rst), 32'd1);
    reset       = 1'b0;
    bus.upg_wen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rl_post_mode", 32'(bus.mode), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/boot_mode_ctrl.md
BOOT_MODE_CTRL -- requirements
Module: boot_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized-high/low cycles needed to change debounced start_uart.
REQ-002 Parameter DMEM_WORDS, default 16384: DMEM depth in words; UART DMEM writes at or above this index are out of range.
REQ-003 clk  in  1  single clock for the whole block.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start_uart  in  1  async switch; high requests UART program-load mode.
REQ-006 upg_wen, upg_addr, upg_data, upg_done  in  1/15/32/1  UART loader write strobe, word address (bit 14 = DMEM), data, done.
REQ-007 cpu_pc, cpu_mem_write, cpu_daddr, cpu_load_type, cpu_wdata  in  16/1/32/3/32  CPU-side memory requests.
REQ-008 upg_rst  out  1  reset to UART loader; high = loader held.
REQ-009 cpu_hold  out  1  forces IFetch reset; high = CPU frozen at PC 0.
REQ-010 imem_wea, imem_addr, imem_din  out  1/14/32  IMEM port.
REQ-011 dmem_we, dmem_addr, dmem_load_type, dmem_din  out  1/32/3/32  DMEM port.
REQ-012 mode  out  2  current state encoding; word_count  out  15  accepted UART writes; load_err  out  1  sticky out-of-range flag; load_abort  out  1  sticky abort flag.

Function
REQ-013 start_uart SHALL pass a 2-flop synchronizer then the debouncer; debounced level start_db changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-014 States: RUN=0, HOLD=1, LOAD=2, DONE=3; mode SHALL equal the state.
REQ-015 RUN -> HOLD when start_db=1; HOLD -> LOAD unconditionally after exactly one cycle.
REQ-016 LOAD -> DONE when upg_done=1; LOAD -> RUN when start_db=0 and upg_done=0, setting load_abort; if both occur in one cycle, DONE wins.
REQ-017 DONE -> RUN when start_db=0; CPU restarts from PC 0 on the first RUN cycle.
REQ-018 upg_rst SHALL be 0 only in LOAD; cpu_hold SHALL be 1 in HOLD, LOAD and DONE.
REQ-019 RUN: imem_wea=0, imem_addr=cpu_pc[15:2], imem_din=0, DMEM driven by cpu_mem_write/cpu_daddr/cpu_load_type/cpu_wdata.
REQ-020 HOLD and DONE: same as RUN except dmem_we=0.
REQ-021 LOAD: imem_wea=upg_wen & ~upg_addr[14], imem_addr=upg_addr[13:0], imem_din=upg_data, dmem_load_type=3'b111, dmem_din=upg_data, dmem_addr=zero-extended {upg_addr[13:0],2'b00}.
REQ-022 LOAD: dmem_we=upg_wen & upg_addr[14] & (upg_addr[13:0] < DMEM_WORDS); an out-of-range DMEM write SHALL be suppressed and SHALL set load_err.
REQ-023 Port muxes SHALL be combinational from registered state, with no cycle of latency.
REQ-024 word_count SHALL increment on each upg_wen cycle in LOAD, including suppressed writes, and saturate at 0x7FFF.
REQ-025 word_count, load_err and load_abort SHALL clear on the RUN -> HOLD transition.
REQ-026 upg_wen SHALL be ignored in every state other than LOAD, including the cycle the FSM leaves LOAD.

Reset
REQ-027 On reset the block SHALL enter RUN and clear the synchronizer, debouncer (start_db=0), word_count, load_err and load_abort.
REQ-028 After reset: upg_rst=1, cpu_hold=0, imem_wea=0, dmem_we=cpu_mem_write, mode=0.
REQ-029 Reset during LOAD SHALL return to RUN on the next edge, with no further IMEM/DMEM writes from the loader.

Structure
REQ-030 Shared package boot_mode_pkg SHALL hold the state enum, LOAD_TYPE_WORD=3'b111 and UPG_DMEM_SEL_BIT=14.
REQ-031 Sub-module sync_debounce (synchronizer plus counter, parameter DEBOUNCE_CYCLES) SHALL produce start_db; the rest of the block stays in boot_mode_ctrl.

Verification
REQ-032 start_uart rises with DEBOUNCE_CYCLES=4 -> mode 0 -> 1 exactly 2+4 cycles after the first high sample, then 2 one cycle later; upg_rst drops in LOAD.
REQ-033 In LOAD, upg_wen with upg_addr=0x0003 and data 0xDEADBEEF -> imem_wea=1, imem_addr=3, dmem_we=0; with upg_addr=0x4005 -> dmem_we=1, dmem_addr=0x14; word_count=2.
REQ-034 DMEM_WORDS=8, LOAD write at upg_addr=0x4008 -> dmem_we=0 and load_err=1 until the next load starts.
REQ-035 upg_done and start_db falling in the same cycle -> DONE with load_abort=0; start_uart low -> RUN and cpu_hold=0.
REQ-036 start_uart dropped mid-LOAD -> RUN with load_abort=1; reset mid-LOAD -> RUN, word_count=0, no writes after the reset edge.
REQ-037 start_uart glitch of 2 cycles with DEBOUNCE_CYCLES=4 -> mode stays 0.
